// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - round-robin arbiter sharing one 3-to-8 decoder select path among 8 requesters
//
// Purpose: grants the decoder select path to one of 8 requesters at a time,
// rotating priority after every tenure and force-ending tenures that reach
// MAX_HOLD cycles. All outputs are registered.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   req      - per-requester level request, bit i = requester i
//   gnt      - one-hot grant, all-zero when idle
//   gnt_idx  - binary owner index {a,b,c}, a = MSB; holds last value while idle
//   gnt_en   - decoder enable, high while a grant is active
//   timeout  - one-cycle pulse when a tenure is force-ended by MAX_HOLD
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_en,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic [2:0]       idx_n;
    logic             en_n;
    logic             to_n;
    logic             win_found;
    logic [2:0]       win_idx;

    // Scan offsets from the highest down so the request closest to ptr
    // (smallest offset) is the one left standing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) begin
                win_found = 1'b1;
                win_idx   = ptr + 3'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        idx_n   = gnt_idx;
        en_n    = gnt_en;
        to_n    = 1'b0;
        case (state)
            IDLE: begin
                en_n = 1'b0;
                if (win_found) begin
                    state_n = GRANT;
                    idx_n   = win_idx;
                    en_n    = 1'b1;
                    hold_n  = CNT_W'(1);
                end
            end
            GRANT: begin
                // Release is checked first so a release coinciding with the
                // hold limit never raises timeout.
                if (!req[gnt_idx]) begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    ptr_n   = gnt_idx + 3'd1;
                end else if (hold_cnt >= CNT_W'(MAX_HOLD)) begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    to_n    = 1'b1;
                    ptr_n   = gnt_idx + 3'd1;
                end else begin
                    hold_n  = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= '0;
            gnt_idx  <= 3'd0;
            gnt_en   <= 1'b0;
            gnt      <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt_idx  <= idx_n;
            gnt_en   <= en_n;
            gnt      <= en_n ? (8'd1 << idx_n) : 8'd0;
            timeout  <= to_n;
        end
    end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - self-checking bench for decoder_rr_arbiter
module tb_decoder_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_en;
    logic       timeout;

    decoder_rr_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_en  (gnt_en),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       en;
        logic [2:0] idx;
        logic       to;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    function automatic void add(input logic [7:0] r, input logic e,
                                input logic [2:0] i, input logic t);
        vec_t v;
        v.req = r; v.en = e; v.idx = i; v.to = t;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                         input logic ee, input logic et);
        n_cmp++;
        if (gnt !== eg || gnt_idx !== ei || gnt_en !== ee || timeout !== et) begin
            n_bad++;
            $display("FAIL %s: got gnt=%h idx=%0d en=%b to=%b, want gnt=%h idx=%0d en=%b to=%b",
                     name, gnt, gnt_idx, gnt_en, timeout, eg, ei, ee, et);
        end
    endtask

    // Called at posedge+1: drive, push expectation, advance one edge, pop and compare.
    task automatic step(input vec_t v, input string name);
        vec_t e;
        req = v.req;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(name, e.en ? (8'd1 << e.idx) : 8'd0, e.idx, e.en, e.to);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = 8'hFF;

        // Round robin from ptr=0: each owner holds 2 cycles, then drops its bit.
        for (int i = 0; i < 8; i++) begin
            add(8'hFF, 1'b1, 3'(i), 1'b0);
            add(8'hFF, 1'b1, 3'(i), 1'b0);
            add(8'hFF & ~(8'd1 << i), 1'b0, 3'(i), 1'b0);
        end
        add(8'hFF, 1'b1, 3'd0, 1'b0);            // wrapped 7 -> 0
        add(8'h00, 1'b0, 3'd0, 1'b0);            // ptr -> 1
        // Single requester 3 for 3 cycles, then next grant starts from ptr=4.
        add(8'h08, 1'b1, 3'd3, 1'b0);
        add(8'h08, 1'b1, 3'd3, 1'b0);
        add(8'h08, 1'b1, 3'd3, 1'b0);
        add(8'h00, 1'b0, 3'd3, 1'b0);
        add(8'h11, 1'b1, 3'd4, 1'b0);
        add(8'h00, 1'b0, 3'd4, 1'b0);            // ptr -> 5
        // Skip: owner 5 releases, then req 0x21 goes to 0.
        add(8'h20, 1'b1, 3'd5, 1'b0);
        add(8'h00, 1'b0, 3'd5, 1'b0);            // ptr -> 6
        add(8'h21, 1'b1, 3'd0, 1'b0);
        add(8'h00, 1'b0, 3'd0, 1'b0);            // ptr -> 1
        // Timeout: req 0x01 held 40 cycles; 16 grant cycles then one idle with timeout.
        for (int c = 0; c < 40; c++) begin
            if ((c % 17) == 16) add(8'h01, 1'b0, 3'd0, 1'b1);
            else                add(8'h01, 1'b1, 3'd0, 1'b0);
        end
        add(8'h00, 1'b0, 3'd0, 1'b0);            // release mid-tenure, ptr -> 1
        // Release on the same edge as the hold limit: no timeout.
        for (int c = 0; c < 16; c++) add(8'h01, 1'b1, 3'd0, 1'b0);
        add(8'h00, 1'b0, 3'd0, 1'b0);            // ptr -> 1
        // Non-owner toggles during a tenure are ignored.
        add(8'h04, 1'b1, 3'd2, 1'b0);
        add(8'h05, 1'b1, 3'd2, 1'b0);
        add(8'hF6, 1'b1, 3'd2, 1'b0);
        add(8'h0C, 1'b1, 3'd2, 1'b0);
        add(8'hFB, 1'b0, 3'd2, 1'b0);            // owner drops, others still high
        add(8'hFB, 1'b1, 3'd3, 1'b0);
        add(8'h00, 1'b0, 3'd3, 1'b0);            // ptr -> 4
        add(8'h40, 1'b1, 3'd6, 1'b0);            // scan 4,5,6
        add(8'h40, 1'b1, 3'd6, 1'b0);

        // Reset held with all requests high.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 8'h00;
        @(posedge clk);
        #1;
        check("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k], $sformatf("vec%0d", k));
        end

        // Async reset mid-tenure of owner 6: outputs clear before the next edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_mid_grant", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req = 8'hC0;
        @(posedge clk);
        #1;
        check("post_reset_grant", 8'h40, 3'd6, 1'b1, 1'b0);
        req = 8'h00;
        @(posedge clk);
        #1;
        check("post_reset_release", 8'h00, 3'd6, 1'b0, 1'b0);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
